// File: rtl/dma_pkg.sv
// Shared DMA definitions: descriptor layout used by the fetch logic, the
// scheduler and the descriptor processor, plus the scheduler state encoding.
package dma_pkg;

  // Descriptor layout
  localparam int DESC_W  = 265;
  localparam int LEN_MSB = 207;
  localparam int LEN_LSB = 192;

  // Credit counter width (range 0..CREDITS, CREDITS <= 63)
  localparam int CRED_W = 6;

  // Scheduler state encoding
  typedef logic [1:0] sched_state_t;
  localparam sched_state_t SCHED_IDLE  = 2'b00;
  localparam sched_state_t SCHED_ISSUE = 2'b01;
  localparam sched_state_t SCHED_HOLD  = 2'b10;

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin pick: first eligible channel at or after rr_ptr,
// wrapping modulo NUM_CH.
module dma_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  // Scan NUM_CH positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Round-robin scheduler sharing the descriptor processor FIFO write port
// between NUM_CH channel descriptor sources. Credit-based flow control keeps
// writes below the FIFO almost-full threshold; zero-length descriptors are
// granted but dropped with an error pulse.
//
// Handshake: ch_req_i[c] is a level valid for ch_desc_i[c]; a one-cycle
// ch_gnt_o[c] pulse means the descriptor was consumed. The requester must
// drop or refresh its request before the IDLE cycle following the grant
// (the HOLD cycle gives it that time).
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CREDITS = 24,
  parameter int DESC_W  = dma_pkg::DESC_W,
  parameter int LEN_MSB = dma_pkg::LEN_MSB,
  parameter int LEN_LSB = dma_pkg::LEN_LSB
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH*DESC_W-1:0] ch_desc_i,
  output logic [NUM_CH-1:0]        ch_gnt_o,
  output logic                     dma_desc_fifo_wr_o,
  output logic [DESC_W-1:0]        dma_desc_fifo_wrdata_o,
  input  logic                     desc_done_i,
  output logic [CRED_W-1:0]        credit_cnt_o,
  output logic                     zero_len_err_o,
  output logic                     credit_ovf_o,
  output logic                     busy_o
);

  localparam int                IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  sched_state_t state_q, state_d;

  logic [NUM_CH-1:0] eligible;
  logic [IDX_W-1:0]  arb_win;
  logic              arb_valid;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  win_q;

  logic [DESC_W-1:0] sel_desc;
  logic              len_zero;
  logic              go;

  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic [DESC_W-1:0] wrdata_q, wrdata_d;
  logic [CRED_W-1:0] credit_q;
  logic              ovf_q;

  assign eligible = ch_req_i & ch_en_i;

  dma_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .winner   (arb_win),
    .valid    (arb_valid)
  );

  // Select the winning channel's descriptor for capture in IDLE.
  always_comb begin
    sel_desc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_win == IDX_W'(c)) sel_desc = ch_desc_i[c*DESC_W +: DESC_W];
    end
  end

  assign len_zero = (sel_desc[LEN_MSB:LEN_LSB] == '0);
  assign go       = (state_q == SCHED_IDLE) && arb_valid && (credit_q != '0);

  // State register plus the registered grant/write outputs and rr pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SCHED_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      busy_q   <= (state_d != SCHED_IDLE);
      wrdata_q <= wrdata_d;
      if (go) win_q <= arb_win;
      if (state_q == SCHED_ISSUE) begin
        rr_ptr_q <= (win_q == IDX_W'(NUM_CH - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  // Next-state: IDLE -> ISSUE on a credited win, ISSUE -> HOLD -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:  if (go) state_d = SCHED_ISSUE;
      SCHED_ISSUE: state_d = SCHED_HOLD;
      SCHED_HOLD:  state_d = SCHED_IDLE;
      default:     state_d = SCHED_IDLE;
    endcase
  end

  // Output decode: values the ISSUE cycle will present, computed in IDLE so
  // every output leaves a flop.
  always_comb begin
    gnt_d    = '0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    wrdata_d = wrdata_q;
    if (go) begin
      gnt_d[arb_win] = 1'b1;
      wr_d           = !len_zero;
      err_d          = len_zero;
      wrdata_d       = sel_desc;
    end
  end

  // Credit counter: a write in ISSUE consumes, desc_done_i returns; a return
  // with the counter already full is held off and flagged sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= CRED_MAX;
      ovf_q    <= 1'b0;
    end else begin
      case ({wr_q, desc_done_i})
        2'b10: credit_q <= credit_q - 1'b1;
        2'b01: begin
          if (credit_q == CRED_MAX) ovf_q <= 1'b1;
          else                      credit_q <= credit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ch_gnt_o               = gnt_q;
  assign dma_desc_fifo_wr_o     = wr_q;
  assign dma_desc_fifo_wrdata_o = wrdata_q;
  assign zero_len_err_o         = err_q;
  assign credit_cnt_o           = credit_q;
  assign credit_ovf_o           = ovf_q;
  assign busy_o                 = busy_q;

endmodule

// File: doc/dma_desc_sched.md
Name: dma_desc_sched

Overview:
- Round-robin scheduler that shares the descriptor processor's 265-bit descriptor FIFO write port between NUM_CH DMA channel descriptor sources.
- Sits between the per-channel descriptor fetch logic and the descriptor processor.
- Tracks FIFO occupancy with a credit counter, so it never writes past the processor FIFO's almost-full threshold.
- Drops zero-length descriptors and flags each drop with an error pulse.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- CREDITS, 24, descriptors allowed in flight in the processor FIFO; equals its almost_full_value.
- DESC_W, 265, descriptor width.
- LEN_MSB, 207, MSB of the bytes-to-transfer field.
- LEN_LSB, 192, LSB of the bytes-to-transfer field.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ch_en_i  in  NUM_CH  per-channel enable (static configuration).
- ch_req_i  in  NUM_CH  channel c has a valid descriptor on ch_desc_i[c].
- ch_desc_i  in  NUM_CH*DESC_W  flattened descriptors; channel c occupies [c*DESC_W +: DESC_W].
- ch_gnt_o  out  NUM_CH  one-hot, single-cycle pulse: channel's descriptor consumed.
- dma_desc_fifo_wr_o  out  1  write strobe to the descriptor processor FIFO.
- dma_desc_fifo_wrdata_o  out  DESC_W  registered descriptor.
- desc_done_i  in  1  one-cycle pulse per descriptor popped by the processor (its FIFO read); returns one credit.
- credit_cnt_o  out  6  available credits.
- zero_len_err_o  out  1  one-cycle pulse when a zero-length descriptor is dropped.
- credit_ovf_o  out  1  sticky; set on credit return while the counter is at CREDITS.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert; release synchronised by the caller):
  - state=IDLE, rr_ptr=0, credit counter=CREDITS.
  - All outputs 0 except credit_cnt_o=CREDITS.
  - dma_desc_fifo_wrdata_o=0.
- Eligible set: ch_req_i & ch_en_i.
- State machine, 3 states:
  - IDLE: if eligible set is non-zero and credits > 0, then winner = first eligible index at or after rr_ptr (wrapping modulo NUM_CH); latch winner index and ch_desc_i[winner]; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (one cycle):
    - ch_gnt_o[winner]=1.
    - If latched length field != 0: dma_desc_fifo_wr_o=1, wrdata=latched descriptor, consume one credit.
    - Else: no write, no credit consumed, zero_len_err_o=1.
    - rr_ptr <= winner+1 (wrapping NUM_CH-1 -> 0). Go to HOLD.
  - HOLD (one cycle): gives the requester time to drop or refresh ch_req_i; go to IDLE.
- Timing:
  - Latency: request sampled in IDLE at cycle N gives grant and write in cycle N+1.
  - Peak rate: one descriptor per 3 cycles.
  - All outputs are registered; no combinational path from ch_req_i to any output.
- Credits:
  - Counter 6 bits, range 0..CREDITS.
  - Write and desc_done_i in the same cycle: net unchanged.
  - desc_done_i with counter at CREDITS and no write that cycle: counter holds, credit_ovf_o set (cleared only by reset).
  - Credits = 0: IDLE stalls; requests stay pending and no grant is issued.
- Arbitration:
  - A channel disabled mid-request is ignored from the next IDLE evaluation.
  - Enable changes during ISSUE/HOLD do not cancel the latched grant.
  - The descriptor is captured in IDLE; changes on ch_desc_i afterwards do not affect the write.
- Reset asserted mid-ISSUE: outputs clear immediately. The partially granted descriptor is lost; the requester must re-present it.

Decomposition:
- Shared package dma_pkg holds:
  - DESC_W, LEN_MSB, LEN_LSB (also used by the descriptor processor and the fetch block).
  - State encoding localparams SCHED_IDLE=2'b00, SCHED_ISSUE=2'b01, SCHED_HOLD=2'b10.
- One sub-module, dma_rr_arb: parameterised NUM_CH, purely combinational; inputs eligible vector and rr_ptr, outputs winner index and a valid flag.
- Credit counter and FSM stay in the top module.

Test Plan:
- Reset release, channel 1 requests with length 0x0040 -> grant pulse on ch_gnt_o[1] and write one cycle after the request is sampled; credit_cnt_o 24 -> 23.
- All 4 channels request continuously with rr_ptr=0 -> grant order 0,1,2,3,0, 3 cycles apart; each write carries the owning channel's descriptor.
- 24 writes with no desc_done_i -> credit_cnt_o=0; next request gets no grant. One desc_done_i pulse -> grant in the following IDLE evaluation; credit_cnt_o back to 0 after the write.
- Channel 2 descriptor with length field 0 -> ch_gnt_o[2] pulse, zero_len_err_o pulse, no write, credits unchanged, rr_ptr=3.
- desc_done_i coincident with the ISSUE write at 10 credits -> credit_cnt_o stays 10. desc_done_i at 24 credits -> credit_ovf_o=1 and stays set.
- reset_n asserted mid-ISSUE -> outputs 0 asynchronously, credit_cnt_o=24. After release, the still-pending channel 3 request is granted with rr_ptr restarting at 0.
